// File: rtl/ultrasonic_echo_emulator_if.sv
// Driver-to-sensor bus of the ultrasonic ranger emulator.
// The range-finder driver is the master; the emulator is the slave.
interface ultrasonic_echo_emulator_if;
    logic       trig_in;
    logic [9:0] range_cm;
    logic       echo_out;
    logic       busy;
    logic       short_trig_err;
    logic       no_object;
    logic [7:0] echo_count;

    modport master (
        output trig_in, range_cm,
        input  echo_out, busy, short_trig_err, no_object, echo_count
    );

    modport slave (
        input  trig_in, range_cm,
        output echo_out, busy, short_trig_err, no_object, echo_count
    );
endinterface

// File: rtl/ultrasonic_echo_emulator.sv
// HC-SR04-style sensor model: qualifies a trigger pulse and answers with an echo
// of 58 us per cm of the programmed range (one us_clk cycle = 1 us).
module ultrasonic_echo_emulator #(
    parameter int MIN_TRIG_US  = 10,
    parameter int BURST_US     = 460,
    parameter int MIN_RANGE_CM = 2,
    parameter int MAX_RANGE_CM = 400,
    parameter int TIMEOUT_US   = 38000,
    parameter int HOLDOFF_US   = 10000
) (
    input  logic                          us_clk,
    input  logic                          resetn,
    ultrasonic_echo_emulator_if.slave     bus
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_TRIG    = 3'd1;
    localparam logic [2:0] S_BURST   = 3'd2;
    localparam logic [2:0] S_ECHO    = 3'd3;
    localparam logic [2:0] S_HOLDOFF = 3'd4;

    localparam logic [15:0] MIN_TRIG   = 16'(MIN_TRIG_US);
    localparam logic [15:0] BURST_LAST = 16'(BURST_US - 1);
    localparam logic [15:0] HOLD_LAST  = 16'(HOLDOFF_US - 1);
    localparam logic [15:0] TIMEOUT_W  = 16'(TIMEOUT_US);
    localparam logic [9:0]  MIN_RNG    = 10'(MIN_RANGE_CM);
    localparam logic [9:0]  MAX_RNG    = 10'(MAX_RANGE_CM);

    logic [2:0]  r_state;
    logic [15:0] r_cnt;
    logic [15:0] r_width;
    logic        r_sync1;
    logic        r_trigS;
    logic        r_trigD;
    logic        r_warm;
    logic        r_armed;
    logic        r_echoOut;
    logic        r_shortErr;
    logic        r_noObject;
    logic [7:0]  r_echoCount;

    logic [15:0] w_rng16;
    logic [15:0] w_scaled;
    logic        w_outOfRange;
    logic        w_risingEdge;

    // rng*58 built from shifts: 64r - 4r - 2r
    assign w_rng16      = {6'd0, bus.range_cm};
    assign w_scaled     = (w_rng16 << 6) - (w_rng16 << 2) - (w_rng16 << 1);
    assign w_outOfRange = (bus.range_cm < MIN_RNG) || (bus.range_cm > MAX_RNG);
    assign w_risingEdge = r_trigS && !r_trigD && r_armed;

    // r_armed stays low until trig_s has been seen low after reset, so a trigger
    // held high across reset release never counts as a rising edge.
    always_ff @(posedge us_clk or negedge resetn) begin
        if (!resetn) begin
            r_sync1 <= 1'b0;
            r_trigS <= 1'b0;
            r_trigD <= 1'b0;
            r_warm  <= 1'b0;
            r_armed <= 1'b0;
        end else begin
            r_sync1 <= bus.trig_in;
            r_trigS <= r_sync1;
            r_trigD <= r_trigS;
            r_warm  <= 1'b1;
            if (r_warm && !r_sync1 && !r_trigS) begin
                r_armed <= 1'b1;
            end
        end
    end

    always_ff @(posedge us_clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_cnt       <= 16'd0;
            r_width     <= 16'd0;
            r_echoOut   <= 1'b0;
            r_shortErr  <= 1'b0;
            r_noObject  <= 1'b0;
            r_echoCount <= 8'd0;
        end else begin
            r_shortErr <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_risingEdge) begin
                        r_state <= S_TRIG;
                        r_cnt   <= 16'd1;
                    end
                end
                S_TRIG: begin
                    if (r_trigS) begin
                        if (r_cnt != 16'hFFFF) begin
                            r_cnt <= r_cnt + 16'd1;
                        end
                    end else if (r_cnt >= MIN_TRIG) begin
                        r_width    <= w_outOfRange ? TIMEOUT_W : w_scaled;
                        r_noObject <= w_outOfRange;
                        r_state    <= S_BURST;
                        r_cnt      <= 16'd0;
                    end else begin
                        r_shortErr <= 1'b1;
                        r_state    <= S_IDLE;
                        r_cnt      <= 16'd0;
                    end
                end
                S_BURST: begin
                    if (r_cnt == BURST_LAST) begin
                        r_state   <= S_ECHO;
                        r_echoOut <= 1'b1;
                        r_cnt     <= 16'd0;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                // The count increment lands on the same edge as the echo falling.
                S_ECHO: begin
                    if (r_cnt == r_width - 16'd1) begin
                        r_state     <= S_HOLDOFF;
                        r_echoOut   <= 1'b0;
                        r_echoCount <= r_echoCount + 8'd1;
                        r_cnt       <= 16'd0;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                S_HOLDOFF: begin
                    if (r_cnt == HOLD_LAST) begin
                        r_state <= S_IDLE;
                        r_cnt   <= 16'd0;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= 16'd0;
                end
            endcase
        end
    end

    assign bus.echo_out       = r_echoOut;
    assign bus.busy           = (r_state != S_IDLE);
    assign bus.short_trig_err = r_shortErr;
    assign bus.no_object      = r_noObject;
    assign bus.echo_count     = r_echoCount;

endmodule

// File: tb/tb_ultrasonic_echo_emulator.sv
// Directed bench for ultrasonic_echo_emulator; burst, holdoff and timeout are
// shortened so that the 256-echo wrap fits in a short run.
module tb_ultrasonic_echo_emulator;

    localparam int BURST   = 16;
    localparam int HOLD    = 30;
    localparam int TIMEOUT = 1000;

    logic us_clk;
    logic resetn;
    int   vecCount = 0;
    int   errCount = 0;
    int   errPulses = 0;
    int   lat;
    int   wid;
    int   cyc;
    int   errBefore;
    int   countBefore;
    int   sawEcho;

    ultrasonic_echo_emulator_if bus ();

    ultrasonic_echo_emulator #(
        .MIN_TRIG_US  (10),
        .BURST_US     (BURST),
        .MIN_RANGE_CM (2),
        .MAX_RANGE_CM (400),
        .TIMEOUT_US   (TIMEOUT),
        .HOLDOFF_US   (HOLD)
    ) dut (
        .us_clk (us_clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial begin
        us_clk = 1'b0;
        forever #5 us_clk = ~us_clk;
    end

    always @(posedge us_clk) begin
        if (bus.short_trig_err) errPulses++;
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        vecCount++;
        if (observed != expected) begin
            errCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge us_clk);
        #1;
    endtask

    task automatic pulseTrig(input int len);
        tick();
        bus.trig_in = 1'b1;
        repeat (len) tick();
        bus.trig_in = 1'b0;
    endtask

    // Latency is counted in edges after the first edge that samples trig_in low.
    task automatic applyStimulus(input int trigLen, input logic [9:0] midRange,
                                 output int latency, output int width);
        pulseTrig(trigLen);
        tick();
        latency = 0;
        while (!bus.echo_out && latency < 200) begin
            tick();
            latency++;
        end
        bus.range_cm = midRange;
        width = 0;
        while (bus.echo_out && width < 40000) begin
            tick();
            width++;
        end
    endtask

    task automatic waitIdle(output int cycles);
        cycles = 0;
        while (bus.busy && cycles < 1000) begin
            tick();
            cycles++;
        end
    endtask

    task automatic watchQuiet(input int cycles, output int echoSeen);
        echoSeen = 0;
        repeat (cycles) begin
            tick();
            if (bus.echo_out) echoSeen = 1;
        end
    endtask

    initial begin
        resetn       = 1'b0;
        bus.trig_in  = 1'b0;
        bus.range_cm = 10'd0;
        repeat (3) tick();
        checkOutput("reset echo_out", int'(bus.echo_out), 0);
        checkOutput("reset busy", int'(bus.busy), 0);
        checkOutput("reset short_trig_err", int'(bus.short_trig_err), 0);
        checkOutput("reset no_object", int'(bus.no_object), 0);
        checkOutput("reset echo_count", int'(bus.echo_count), 0);
        resetn = 1'b1;
        repeat (5) tick();

        // Nominal 100 cm measurement with a mid-echo range change to 50 cm
        bus.range_cm = 10'd100;
        applyStimulus(12, 10'd50, lat, wid);
        checkOutput("r100 latency", lat, 2 + BURST);
        checkOutput("r100 width", wid, 5800);
        checkOutput("r100 no_object", int'(bus.no_object), 0);
        checkOutput("r100 echo_count", int'(bus.echo_count), 1);
        checkOutput("r100 busy in holdoff", int'(bus.busy), 1);
        waitIdle(cyc);
        checkOutput("r100 holdoff length", cyc, HOLD);
        applyStimulus(12, 10'd50, lat, wid);
        checkOutput("r50 width", wid, 2900);
        checkOutput("r50 echo_count", int'(bus.echo_count), 2);
        waitIdle(cyc);

        // 9-cycle trigger is rejected, 10-cycle trigger is accepted
        errBefore = errPulses;
        bus.range_cm = 10'd2;
        pulseTrig(9);
        watchQuiet(20, sawEcho);
        checkOutput("short err pulses", errPulses - errBefore, 1);
        checkOutput("short no echo", sawEcho, 0);
        checkOutput("short busy", int'(bus.busy), 0);
        checkOutput("short echo_count", int'(bus.echo_count), 2);
        applyStimulus(10, 10'd2, lat, wid);
        checkOutput("trig10 width r2", wid, 116);
        checkOutput("trig10 no_object", int'(bus.no_object), 0);
        checkOutput("trig10 echo_count", int'(bus.echo_count), 3);
        waitIdle(cyc);

        // Range boundaries
        bus.range_cm = 10'd400;
        applyStimulus(12, 10'd400, lat, wid);
        checkOutput("r400 width", wid, 23200);
        checkOutput("r400 no_object", int'(bus.no_object), 0);
        waitIdle(cyc);
        bus.range_cm = 10'd401;
        applyStimulus(12, 10'd401, lat, wid);
        checkOutput("r401 width", wid, TIMEOUT);
        checkOutput("r401 no_object", int'(bus.no_object), 1);
        waitIdle(cyc);
        bus.range_cm = 10'd1;
        applyStimulus(12, 10'd1, lat, wid);
        checkOutput("r1 width", wid, TIMEOUT);
        checkOutput("r1 no_object", int'(bus.no_object), 1);
        waitIdle(cyc);
        checkOutput("r1 echo_count", int'(bus.echo_count), 6);

        // Triggers during ECHO and HOLDOFF are ignored
        bus.range_cm = 10'd2;
        errBefore = errPulses;
        countBefore = int'(bus.echo_count);
        pulseTrig(12);
        cyc = 0;
        while (!bus.echo_out && cyc < 200) begin
            tick();
            cyc++;
        end
        pulseTrig(12);
        cyc = 0;
        while (bus.echo_out && cyc < 500) begin
            tick();
            cyc++;
        end
        pulseTrig(5);
        waitIdle(cyc);
        watchQuiet(20, sawEcho);
        checkOutput("ignored trig err pulses", errPulses - errBefore, 0);
        checkOutput("ignored trig no echo", sawEcho, 0);
        checkOutput("ignored trig echo_count", int'(bus.echo_count), countBefore + 1);
        applyStimulus(12, 10'd2, lat, wid);
        checkOutput("after idle width", wid, 116);
        checkOutput("after idle echo_count", int'(bus.echo_count), countBefore + 2);
        waitIdle(cyc);

        // Reset mid-echo, trigger held high through release
        pulseTrig(12);
        cyc = 0;
        while (!bus.echo_out && cyc < 200) begin
            tick();
            cyc++;
        end
        repeat (10) tick();
        bus.trig_in = 1'b1;
        resetn = 1'b0;
        #1;
        checkOutput("async reset echo_out", int'(bus.echo_out), 0);
        checkOutput("async reset echo_count", int'(bus.echo_count), 0);
        checkOutput("async reset busy", int'(bus.busy), 0);
        repeat (3) tick();
        resetn = 1'b1;
        watchQuiet(50, sawEcho);
        checkOutput("held trig no echo", sawEcho, 0);
        checkOutput("held trig busy", int'(bus.busy), 0);
        bus.trig_in = 1'b0;
        repeat (3) tick();
        for (int i = 0; i < 255; i++) begin
            applyStimulus(10, 10'd2, lat, wid);
            waitIdle(cyc);
        end
        checkOutput("echo_count at 255", int'(bus.echo_count), 255);
        applyStimulus(10, 10'd2, lat, wid);
        checkOutput("wrap width", wid, 116);
        checkOutput("wrap echo_count", int'(bus.echo_count), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule
